// File: rtl/video_source_gen.sv
// video_source_gen: raster timing and 4:2:2 test-pattern source.
// Produces fvht timing flags and a 20-bit {luma, chroma} sample stream with
// one of four test patterns. Pattern changes apply only at frame boundaries.
// A start/stop state machine ensures frames are never truncated.
//
// Ports:
//   clk_i          clock
//   rst_ni         asynchronous active-low reset
//   cen_i          clock enable; all state advances only when high
//   enable_i       request to run the generator
//   pattern_sel_i  0 colour bars, 1 flat colour, 2 luma ramp, 3 black
//   flat_colour_i  {luma, chroma} used by the flat pattern (sampled live)
//   fvht_o         [3] F parity, [2] V blank, [1] H blank, [0] T reference
//   video_o        {luma[19:10], chroma[9:0]}
//   sof_o          one-cen pulse aligned with sample h=0, v=0
//   busy_o         high while a frame is being produced (RUN or STOPPING)
module video_source_gen #(
  parameter int unsigned H_ACTIVE = 720,
  parameter int unsigned H_TOTAL  = 858,
  parameter int unsigned V_ACTIVE = 487,
  parameter int unsigned V_TOTAL  = 525
) (
  input  logic        clk_i,
  input  logic        rst_ni,
  input  logic        cen_i,
  input  logic        enable_i,
  input  logic [1:0]  pattern_sel_i,
  input  logic [19:0] flat_colour_i,
  output logic [3:0]  fvht_o,
  output logic [19:0] video_o,
  output logic        sof_o,
  output logic        busy_o
);

  localparam int unsigned BAR_W = H_ACTIVE / 8;
  localparam int unsigned HW    = $clog2(H_TOTAL);
  localparam int unsigned VW    = $clog2(V_TOTAL);
  localparam int unsigned SW    = (BAR_W > 1) ? $clog2(BAR_W) : 1;

  localparam logic [3:0]  BLANK_FVHT  = 4'b0110;
  localparam logic [19:0] BLANK_VIDEO = 20'h10200;
  localparam logic [9:0]  Y_BLACK     = 10'd64;
  localparam logic [9:0]  C_NEUTRAL   = 10'd512;

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    RUN      = 2'd1,
    STOPPING = 2'd2
  } state_t;

  state_t        state;
  logic [HW-1:0] h_cnt;
  logic [VW-1:0] v_cnt;
  logic          f;
  logic [1:0]    pattern_reg;
  logic [2:0]    bar_idx;
  logic [SW-1:0] bar_smp;

  logic          h_last;
  logic          v_last;
  logic          frame_last;

  assign h_last     = (h_cnt == HW'(H_TOTAL - 1));
  assign v_last     = (v_cnt == VW'(V_TOTAL - 1));
  assign frame_last = h_last && v_last;

  // Colour bar lookup for the current bar
  logic [9:0] bar_y;
  logic [9:0] bar_cb;
  logic [9:0] bar_cr;

  always_comb begin
    bar_y  = Y_BLACK;
    bar_cb = C_NEUTRAL;
    bar_cr = C_NEUTRAL;
    case (bar_idx)
      3'd0: begin bar_y = 10'd720; bar_cb = 10'd512; bar_cr = 10'd512; end
      3'd1: begin bar_y = 10'd648; bar_cb = 10'd176; bar_cr = 10'd568; end
      3'd2: begin bar_y = 10'd524; bar_cb = 10'd624; bar_cr = 10'd176; end
      3'd3: begin bar_y = 10'd448; bar_cb = 10'd288; bar_cr = 10'd232; end
      3'd4: begin bar_y = 10'd336; bar_cb = 10'd736; bar_cr = 10'd792; end
      3'd5: begin bar_y = 10'd260; bar_cb = 10'd400; bar_cr = 10'd848; end
      3'd6: begin bar_y = 10'd140; bar_cb = 10'd848; bar_cr = 10'd456; end
      default: begin bar_y = 10'd64; bar_cb = 10'd512; bar_cr = 10'd512; end
    endcase
  end

  // Timing flags and sample value for the current counter position
  logic        h_blank;
  logic        v_blank;
  logic        t_ref;
  logic        sof_pos;
  logic [19:0] pix;

  always_comb begin
    h_blank = (h_cnt >= HW'(H_ACTIVE));
    v_blank = (v_cnt >= VW'(V_ACTIVE));
    t_ref   = (h_cnt == HW'(H_ACTIVE)) || h_last;
    sof_pos = (h_cnt == '0) && (v_cnt == '0);
    pix     = BLANK_VIDEO;
    case (pattern_reg)
      // odd samples carry Cr, even samples carry Cb
      2'd0:    pix = {bar_y, h_cnt[0] ? bar_cr : bar_cb};
      2'd1:    pix = flat_colour_i;
      2'd2:    pix = {Y_BLACK + 10'(9'(h_cnt)), C_NEUTRAL};
      default: pix = {Y_BLACK, C_NEUTRAL};
    endcase
    if (h_blank || v_blank) begin
      pix = BLANK_VIDEO;
    end
  end

  // Start/stop FSM, raster counters and registered outputs
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state       <= IDLE;
      h_cnt       <= '0;
      v_cnt       <= '0;
      f           <= 1'b0;
      pattern_reg <= 2'd0;
      bar_idx     <= '0;
      bar_smp     <= '0;
      fvht_o      <= BLANK_FVHT;
      video_o     <= BLANK_VIDEO;
      sof_o       <= 1'b0;
      busy_o      <= 1'b0;
    end else if (cen_i) begin
      case (state)
        IDLE: begin
          h_cnt   <= '0;
          v_cnt   <= '0;
          f       <= 1'b0;
          bar_idx <= '0;
          bar_smp <= '0;
          fvht_o  <= BLANK_FVHT;
          video_o <= BLANK_VIDEO;
          sof_o   <= 1'b0;
          if (enable_i) begin
            state       <= RUN;
            pattern_reg <= pattern_sel_i;
            busy_o      <= 1'b1;
          end else begin
            busy_o <= 1'b0;
          end
        end

        RUN, STOPPING: begin
          fvht_o  <= {f, v_blank, h_blank, t_ref};
          video_o <= pix;
          sof_o   <= sof_pos;

          if (h_last) begin
            h_cnt   <= '0;
            bar_idx <= '0;
            bar_smp <= '0;
            if (v_last) begin
              v_cnt       <= '0;
              f           <= ~f;
              pattern_reg <= pattern_sel_i;
            end else begin
              v_cnt <= v_cnt + VW'(1);
            end
          end else begin
            h_cnt <= h_cnt + HW'(1);
            // bar counter replaces h_cnt / BAR_W
            if (bar_smp == SW'(BAR_W - 1)) begin
              bar_smp <= '0;
              bar_idx <= bar_idx + 3'd1;
            end else begin
              bar_smp <= bar_smp + SW'(1);
            end
          end

          // Stop requests take effect only once the frame has completed
          if (state == RUN) begin
            if (!enable_i) begin
              if (frame_last) begin
                state  <= IDLE;
                busy_o <= 1'b0;
              end else begin
                state <= STOPPING;
              end
            end
          end else begin
            if (frame_last) begin
              state  <= IDLE;
              busy_o <= 1'b0;
            end else if (enable_i) begin
              state <= RUN;
            end
          end
        end

        default: begin
          state  <= IDLE;
          busy_o <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_video_source_gen.sv
// Scoreboard bench for video_source_gen with a reduced 24x6 raster.
module tb_video_source_gen;

  localparam int H_ACT = 16;
  localparam int H_TOT = 24;
  localparam int V_ACT = 4;
  localparam int V_TOT = 6;
  localparam int BAR_W = H_ACT / 8;
  localparam int FRAME = H_TOT * V_TOT;

  logic        clk;
  logic        rst_ni;
  logic        cen;
  logic        enable;
  logic [1:0]  pattern_sel;
  logic [19:0] flat_colour;
  logic [3:0]  fvht;
  logic [19:0] video;
  logic        sof;
  logic        busy;

  video_source_gen #(
    .H_ACTIVE(H_ACT), .H_TOTAL(H_TOT), .V_ACTIVE(V_ACT), .V_TOTAL(V_TOT)
  ) dut (
    .clk_i(clk), .rst_ni(rst_ni), .cen_i(cen), .enable_i(enable),
    .pattern_sel_i(pattern_sel), .flat_colour_i(flat_colour),
    .fvht_o(fvht), .video_o(video), .sof_o(sof), .busy_o(busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct packed {
    logic [3:0]  fvht;
    logic [19:0] video;
    logic        sof;
    logic        busy;
    int          tag;
  } exp_t;

  // Hand-entered colour bar table (Y, Cb, Cr)
  logic [9:0] bar_y  [8] = '{10'd720, 10'd648, 10'd524, 10'd448, 10'd336, 10'd260, 10'd140, 10'd64};
  logic [9:0] bar_cb [8] = '{10'd512, 10'd176, 10'd624, 10'd288, 10'd736, 10'd400, 10'd848, 10'd512};
  logic [9:0] bar_cr [8] = '{10'd512, 10'd568, 10'd176, 10'd232, 10'd792, 10'd848, 10'd456, 10'd512};

  exp_t exp_q[$];
  exp_t last_e;
  event mon_ev;
  int   n_checks = 0;
  int   n_fail   = 0;
  int   frame_no = 0;

  // Per-frame stimulus controls (frame sample index, -1 = unused)
  int          drop_at  = -1;
  int          raise_at = -1;
  int          chg_at   = -1;
  logic [1:0]  chg_val  = 2'd0;
  int          stall_at = -1;
  int          flat_at  = -1;
  logic [19:0] flat_val = 20'h0;
  int          rst_at   = -1;

  task automatic check(input string name, input logic [19:0] act, input logic [19:0] want, input int tag);
    n_checks++;
    if (act !== want) begin
      n_fail++;
      $display("FAIL %s tag=%0d got=%h want=%h", name, tag, act, want);
    end
  endtask

  // Monitor: compares DUT outputs against the oldest expectation
  initial begin
    exp_t e;
    forever begin
      @(negedge clk or mon_ev);
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        check("fvht",  20'(fvht), 20'(e.fvht), e.tag);
        check("video", video,     e.video,     e.tag);
        check("sof",   20'(sof),  20'(e.sof),  e.tag);
        check("busy",  20'(busy), 20'(e.busy), e.tag);
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

  function automatic exp_t blank_e(input logic b, input int tag);
    exp_t e;
    e.fvht  = 4'b0110;
    e.video = 20'h10200;
    e.sof   = 1'b0;
    e.busy  = b;
    e.tag   = tag;
    return e;
  endfunction

  function automatic exp_t sample_e(input int h, input int v, input logic fpar,
                                    input logic [1:0] pat, input logic b, input int tag);
    exp_t e;
    logic hb;
    logic vb;
    int   bi;
    hb      = (h >= H_ACT);
    vb      = (v >= V_ACT);
    bi      = (h / BAR_W) % 8;
    e.fvht  = {fpar, vb, hb, (h == H_ACT) || (h == H_TOT - 1)};
    e.sof   = (h == 0) && (v == 0);
    e.busy  = b;
    e.tag   = tag;
    if (hb || vb) begin
      e.video = 20'h10200;
    end else begin
      case (pat)
        2'd0:    e.video = {bar_y[bi], ((h % 2) == 1) ? bar_cr[bi] : bar_cb[bi]};
        2'd1:    e.video = flat_colour;
        2'd2:    e.video = {10'(64 + h), 10'd512};
        default: e.video = {10'd64, 10'd512};
      endcase
    end
    return e;
  endfunction

  // Push one expectation for the output after the next edge, then advance
  task automatic step(input exp_t e);
    exp_q.push_back(e);
    last_e = e;
    @(posedge clk);
    #2;
  endtask

  task automatic clear_ctrl();
    drop_at = -1; raise_at = -1; chg_at = -1; stall_at = -1; flat_at = -1; rst_at = -1;
  endtask

  // One frame of expected samples; stopped=1 if the run ended (stop or reset)
  task automatic run_frame(input logic fpar, input logic [1:0] pat, output bit stopped);
    exp_t e;
    int   idx;
    stopped = 1'b0;
    frame_no++;
    for (int v = 0; v < V_TOT; v++) begin
      for (int h = 0; h < H_TOT; h++) begin
        idx = v * H_TOT + h;
        if (idx == drop_at)  enable = 1'b0;
        if (idx == raise_at) enable = 1'b1;
        if (idx == chg_at)   pattern_sel = chg_val;
        if (idx == flat_at)  flat_colour = flat_val;
        if (idx == stall_at) begin
          cen = 1'b0;
          step(last_e);
          step(last_e);
          cen = 1'b1;
        end
        e = sample_e(h, v, fpar, pat,
                     (idx == FRAME - 1) ? enable : 1'b1, frame_no * 1000 + idx);
        step(e);
        if (idx == FRAME - 1 && !enable) stopped = 1'b1;
        if (idx == rst_at) begin
          // asynchronous reset in the middle of the low phase
          @(negedge clk);
          #1;
          rst_ni = 1'b0;
          #1;
          exp_q.push_back(blank_e(1'b0, 90000 + frame_no));
          -> mon_ev;
          #1;
          stopped = 1'b1;
          clear_ctrl();
          return;
        end
      end
    end
    clear_ctrl();
  endtask

  initial begin
    bit st;
    rst_ni      = 1'b0;
    cen         = 1'b1;
    enable      = 1'b0;
    pattern_sel = 2'd0;
    flat_colour = 20'h0;

    // Reset values, then idle with enable low
    step(blank_e(1'b0, 1));
    step(blank_e(1'b0, 2));
    rst_ni = 1'b1;
    step(blank_e(1'b0, 3));

    // Continuous colour bars: F = 0, 1, 0, then a stop request mid-frame
    enable = 1'b1;
    step(blank_e(1'b1, 4));
    run_frame(1'b0, 2'd0, st);
    run_frame(1'b1, 2'd0, st);
    run_frame(1'b0, 2'd0, st);
    drop_at = 2 * H_TOT + 5;
    run_frame(1'b1, 2'd0, st);
    step(blank_e(1'b0, 5));
    step(blank_e(1'b0, 6));

    // Stop request withdrawn at line 3; next frame follows contiguously
    enable = 1'b1;
    step(blank_e(1'b1, 7));
    drop_at  = 2 * H_TOT + 5;
    raise_at = 3 * H_TOT;
    run_frame(1'b0, 2'd0, st);
    chg_at  = 30;
    chg_val = 2'd2;
    run_frame(1'b1, 2'd0, st);

    // Ramp with a two-cycle clock-enable stall in active video
    stall_at = H_TOT + 2;
    chg_at   = 60;
    chg_val  = 2'd1;
    flat_colour = 20'hABCDE;
    run_frame(1'b0, 2'd2, st);

    // Flat colour, changed live mid-frame
    flat_at  = 50;
    flat_val = 20'h12345;
    chg_at   = 100;
    chg_val  = 2'd3;
    run_frame(1'b1, 2'd1, st);

    // Black frame interrupted by reset at line 1 sample 10
    rst_at = H_TOT + 10;
    run_frame(1'b0, 2'd3, st);
    pattern_sel = 2'd2;
    step(blank_e(1'b0, 8));
    rst_ni = 1'b1;
    step(blank_e(1'b1, 9));
    run_frame(1'b0, 2'd2, st);
    drop_at = 0;
    run_frame(1'b1, 2'd2, st);
    step(blank_e(1'b0, 10));

    @(negedge clk);
    #1;
    n_checks++;
    if (exp_q.size() != 0) begin
      n_fail++;
      $display("FAIL drain got=%0d want=0", exp_q.size());
    end
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
